mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 8: maximum MEM-state cycles allowed without MemReady.
REQ-002 Clk  input  1  system clock, rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Instr  input  32  current instruction word from the fetch unit.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 MemReady  input  1  data-memory completion handshake.
REQ-007 IrWrite  output  1  latch Instr into the instruction register.
REQ-008 PcEn  output  1  one-cycle pulse; fetch unit advances.
REQ-009 IfBeq  output  1  branch-taken qualifier for the fetch unit.
REQ-010 RegWrite  output  1  register-file write enable.
REQ-011 RegDst  output  1  1 = rd, 0 = rt destination.
REQ-012 AluSrc  output  1  1 = extended immediate operand.
REQ-013 ExtOp  output  1  1 = sign-extend, 0 = zero-extend imm16.
REQ-014 AluOp  output  2  0 ADD, 1 SUB, 2 OR, 3 LUI.
REQ-015 MemRead / MemWrite  output  1 each  data-memory strobes.
REQ-016 MemToReg  output  1  write-back source is memory.
REQ-017 Busy  output  1  controller not halted.
REQ-018 Fault  output  1  sticky illegal-instruction or memory-timeout flag.

Function
REQ-019 Decoded set SHALL be: op 0 with funct 0x21 addu or 0x23 subu; ori 0x0d; lui 0x0f; lw 0x23; sw 0x2b; beq 0x04. Everything else, including 0x00000000, SHALL be illegal.
REQ-020 States SHALL be FETCH, DECODE, EXEC, MEM, WB, BR, HALT, with controls as Moore outputs of state plus the latched IR.
REQ-021 FETCH: IrWrite=1 for one cycle, then DECODE.
REQ-022 DECODE: illegal -> HALT; beq -> BR; otherwise -> EXEC.
REQ-023 EXEC: lw/sw -> MEM (AluOp ADD, AluSrc 1, ExtOp 1); all other instructions -> WB.
REQ-024 MEM: MemRead (lw) or MemWrite (sw) held until MemReady; then sw -> FETCH with PcEn=1, lw -> WB. MemReady outside MEM SHALL be ignored.
REQ-025 Timeout: wait counter cleared on MEM entry and incremented on each MEM cycle with MemReady=0. MemReady in the WAIT_MAX-th MEM cycle completes normally; its absence -> HALT with Fault=1.
REQ-026 WB: RegWrite=1 and PcEn=1 for one cycle, then FETCH. MemToReg=1 only for lw. RegDst=1 only for addu/subu.
REQ-027 BR: AluOp SUB, IfBeq=Zero, PcEn=1, then FETCH.
REQ-028 Latency: addu/subu/ori/lui 4 cycles; beq 3 cycles; sw 4+waits; lw 5+waits.
REQ-029 ori SHALL use ExtOp=0 and AluOp OR; lui SHALL use AluOp LUI.
REQ-030 HALT: all strobes 0, Busy=0, no exit except Reset.

Reset
REQ-031 Reset assertion SHALL immediately force state FETCH, wait counter 0, Fault 0, and every output 0, including mid-MEM.
REQ-032 The first rising Clk after Reset deasserts SHALL be a FETCH cycle with IrWrite=1 and Busy=1.

Configuration
REQ-033 With CTRL_PERF_CNT_EN defined: output RetireCnt[31:0] SHALL count PcEn pulses, reset to 0, and wrap from 0xFFFFFFFF to 0.
REQ-034 Without CTRL_PERF_CNT_EN: the port and the counter SHALL be absent, with all other behaviour identical.

Structure
REQ-035 Shared package mips_pkg SHALL hold opcode/funct constants, the state enum and the AluOp encoding.
REQ-036 Combinational sub-module main_dec SHALL map the IR to the instruction class and the illegal flag; mc_ctrl holds the FSM and counters.

Verification
REQ-037 Reset, Instr=0x00228021 -> cycle 4 has RegWrite=1, RegDst=1, AluOp=ADD, PcEn=1.
REQ-038 Instr=0x8c330002, MemReady low 2 MEM cycles then high -> MemRead for 3 cycles, WB with MemToReg=1, PcEn at cycle 7.
REQ-039 Instr=0x1042ffe0 -> with Zero=1, IfBeq=1 and PcEn=1 at cycle 3; with Zero=0, IfBeq=0 and PcEn=1 at cycle 3.
REQ-040 Instr=0xffffffff -> HALT after DECODE, Fault=1, Busy=0, no further PcEn.
REQ-041 Instr=0xac310002, MemReady stuck 0, WAIT_MAX=8 -> 8 MemWrite cycles, then HALT with Fault=1.
REQ-042 Reset pulsed during lw MEM -> all outputs 0 asynchronously; first clock after release is FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, FSM state, ALU encoding and control bundle
// for the multicycle MIPS-subset controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_OR = 2'd2, ALU_LUI = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_ILL
  } iclass_e;

  typedef struct packed {
    logic    ir_write;
    logic    pc_en;
    logic    if_beq;
    logic    reg_write;
    logic    reg_dst;
    logic    alu_src;
    logic    ext_op;
    alu_op_e alu_op;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    busy;
    logic    fault;
  } ctl_t;

endpackage

// File: rtl/mc_ctrl_main_dec.sv
// Main decoder: maps the latched opcode/funct to an instruction class and
// flags anything outside the supported subset as illegal.
module main_dec
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_e    cls,
  output logic       illegal
);

  always_comb begin
    cls = C_ILL;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU)      cls = C_ADDU;
        else if (funct == FN_SUBU) cls = C_SUBU;
      end
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      default: cls = C_ILL;
    endcase
    illegal = (cls == C_ILL);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle controller FSM with memory-wait timeout and sticky fault.
// Optional retire counter (RetireCnt) when CTRL_PERF_CNT_EN is defined.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int WAIT_MAX = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        IrWrite,
  output logic        PcEn,
  output logic        IfBeq,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        AluSrc,
  output logic        ExtOp,
  output logic [1:0]  AluOp,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        Busy,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0] RetireCnt,
`endif
  output logic        Fault
);

  localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

  state_e         state_q, state_d;
  logic [5:0]     op_q, op_d, fn_q, fn_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           fault_q, fault_d;
  iclass_e        cls;
  logic           illegal, is_mem;
  ctl_t           ctl, ctl_o;

  // Only opcode and funct steer control; the operand fields go to the datapath.
  logic unused_instr;
  assign unused_instr = ^Instr[25:6];

  main_dec u_dec (.op(op_q), .funct(fn_q), .cls(cls), .illegal(illegal));

  assign is_mem = (cls == C_LW) || (cls == C_SW);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    wait_d  = wait_q;
    case (state_q)
      S_FETCH: begin
        op_d    = Instr[31:26];
        fn_d    = Instr[5:0];
        state_d = S_DECODE;
      end
      S_DECODE: state_d = illegal ? S_HALT : (cls == C_BEQ) ? S_BR : S_EXEC;
      S_EXEC: begin
        state_d = is_mem ? S_MEM : S_WB;
        wait_d  = '0;
      end
      S_MEM: begin
        if (MemReady)                state_d = (cls == C_SW) ? S_FETCH : S_WB;
        else if (wait_q == WAIT_LAST) state_d = S_HALT;
        else                          wait_d  = wait_q + 1'b1;
      end
      S_WB, S_BR: state_d = S_FETCH;
      default:    state_d = S_HALT;
    endcase
    fault_d = fault_q | (state_d == S_HALT);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    ctl       = '0;
    ctl.busy  = (state_q != S_HALT);
    ctl.fault = fault_q;
    // ALU steering stays stable from EXEC through write-back.
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      case (cls)
        C_SUBU:     ctl.alu_op = ALU_SUB;
        C_ORI:      begin ctl.alu_op = ALU_OR;  ctl.alu_src = 1'b1; end
        C_LUI:      begin ctl.alu_op = ALU_LUI; ctl.alu_src = 1'b1; end
        C_LW, C_SW: begin ctl.alu_src = 1'b1; ctl.ext_op = 1'b1; end
        default:    ctl.alu_op = ALU_ADD;
      endcase
    end
    case (state_q)
      S_FETCH: ctl.ir_write = 1'b1;
      S_MEM: begin
        ctl.mem_read  = (cls == C_LW);
        ctl.mem_write = (cls == C_SW);
        ctl.pc_en     = (cls == C_SW) && MemReady;
      end
      S_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.pc_en      = 1'b1;
        ctl.reg_dst    = (cls == C_ADDU) || (cls == C_SUBU);
        ctl.mem_to_reg = (cls == C_LW);
      end
      S_BR: begin
        ctl.alu_op = ALU_SUB;
        ctl.if_beq = Zero;
        ctl.pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset silences every output immediately, not just at the next edge.
  assign ctl_o    = Reset ? '0 : ctl;
  assign IrWrite  = ctl_o.ir_write;
  assign PcEn     = ctl_o.pc_en;
  assign IfBeq    = ctl_o.if_beq;
  assign RegWrite = ctl_o.reg_write;
  assign RegDst   = ctl_o.reg_dst;
  assign AluSrc   = ctl_o.alu_src;
  assign ExtOp    = ctl_o.ext_op;
  assign AluOp    = ctl_o.alu_op;
  assign MemRead  = ctl_o.mem_read;
  assign MemWrite = ctl_o.mem_write;
  assign MemToReg = ctl_o.mem_to_reg;
  assign Busy     = ctl_o.busy;
  assign Fault    = ctl_o.fault;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retire_q, retire_d;
  always_comb retire_d = retire_q + 32'(ctl.pc_en);
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end
  assign RetireCnt = retire_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl: per-instruction expected
// cycle traces built from the instruction rules, compared every cycle.
module tb_mc_ctrl;
  localparam int WAIT_MAX = 8;
  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3,
                 K_LW = 4, K_SW = 5, K_BEQ = 6, K_ILL = 7;

  logic        Clk = 1'b0, Reset = 1'b1, Zero = 1'b0, MemReady = 1'b0;
  logic [31:0] Instr = '0;
  logic        IrWrite, PcEn, IfBeq, RegWrite, RegDst, AluSrc, ExtOp;
  logic        MemRead, MemWrite, MemToReg, Busy, Fault;
  logic [1:0]  AluOp;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] RetireCnt;
  int unsigned ret_model = 0;
`endif

  mc_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .MemReady(MemReady),
    .IrWrite(IrWrite), .PcEn(PcEn), .IfBeq(IfBeq), .RegWrite(RegWrite),
    .RegDst(RegDst), .AluSrc(AluSrc), .ExtOp(ExtOp), .AluOp(AluOp),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .Busy(Busy),
`ifdef CTRL_PERF_CNT_EN
    .RetireCnt(RetireCnt),
`endif
    .Fault(Fault));

  always #5 Clk = ~Clk;

  // [13]IrWrite [12]PcEn [11]IfBeq [10]RegWrite [9]RegDst [8]AluSrc [7]ExtOp
  // [6:5]AluOp [4]MemRead [3]MemWrite [2]MemToReg [1]Busy [0]Fault
  typedef struct {
    logic [13:0] v;
    logic        ib;
    logic        mr;
    logic [31:0] instr;
  } cyc_t;

  cyc_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0, cyc_idx = 0, zforce = -1;
  int          pc_first, mrd_n, mwr_n;
  logic [13:0] snap [1:40];

  function automatic logic [13:0] outs();
    return {IrWrite, PcEn, IfBeq, RegWrite, RegDst, AluSrc, ExtOp, AluOp,
            MemRead, MemWrite, MemToReg, Busy, Fault};
  endfunction

  function automatic int classify(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26]; fn = ins[5:0];
    if (op == 6'h00 && fn == 6'h21) return K_ADDU;
    if (op == 6'h00 && fn == 6'h23) return K_SUBU;
    if (op == 6'h0d) return K_ORI;
    if (op == 6'h0f) return K_LUI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2b) return K_SW;
    if (op == 6'h04) return K_BEQ;
    return K_ILL;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_idx, got, exp);
    end
  endtask

  task automatic push(input logic [13:0] v, input logic ib, input logic mr, input logic [31:0] ins);
    cyc_t c;
    c.v = v; c.ib = ib; c.mr = mr; c.instr = ins;
    exp_q.push_back(c);
  endtask

  // Expected per-cycle trace of one instruction; waits = MEM cycles without
  // MemReady before completion, tmo = MemReady never arrives.
  task automatic build(input logic [31:0] ins, input int waits, input bit tmo, output bit halts);
    int k = classify(ins);
    logic [13:0] alu, v;
    int n;
    alu = '0;
    case (k)
      K_SUBU: alu[6:5] = 2'd1;
      K_ORI:  begin alu[6:5] = 2'd2; alu[8] = 1'b1; end
      K_LUI:  begin alu[6:5] = 2'd3; alu[8] = 1'b1; end
      K_LW, K_SW: begin alu[8] = 1'b1; alu[7] = 1'b1; end
      default: ;
    endcase
    halts = 1'b0;
    push(14'b10000000000010, 1'b0, 1'($urandom), ins);
    push(14'b00000000000010, 1'b0, 1'($urandom), $urandom);
    if (k == K_ILL) begin
      for (int i = 0; i < 3; i++) push(14'b00000000000001, 1'b0, 1'($urandom), $urandom);
      halts = 1'b1;
      return;
    end
    if (k == K_BEQ) begin
      push(14'b01000000100010, 1'b1, 1'($urandom), $urandom);
      return;
    end
    push(alu | 14'b10, 1'b0, 1'($urandom), $urandom);
    if (k == K_LW || k == K_SW) begin
      n = tmo ? WAIT_MAX : waits + 1;
      for (int i = 1; i <= n; i++) begin
        logic rdy = !tmo && (i == n);
        v = alu | 14'b10;
        if (k == K_LW) v[4] = 1'b1; else v[3] = 1'b1;
        if (k == K_SW && rdy) v[12] = 1'b1;
        push(v, 1'b0, rdy, $urandom);
      end
      if (tmo) begin
        for (int i = 0; i < 3; i++) push(14'b00000000000001, 1'b0, 1'($urandom), $urandom);
        halts = 1'b1;
        return;
      end
      if (k == K_SW) return;
    end
    v = alu | 14'b10;
    v[10] = 1'b1; v[12] = 1'b1;
    v[9] = (k == K_ADDU || k == K_SUBU);
    v[2] = (k == K_LW);
    push(v, 1'b0, 1'($urandom), $urandom);
  endtask

  // Replay up to nmax queued cycles; each step starts at a falling edge.
  task automatic run(input int nmax);
    int n = 0;
    logic [13:0] ev, got;
    pc_first = 0; mrd_n = 0; mwr_n = 0;
    for (int i = 1; i <= 40; i++) snap[i] = 'x;
    while (exp_q.size() > 0 && n < nmax) begin
      cyc_t e = exp_q.pop_front();
      Instr = e.instr; MemReady = e.mr;
      Zero = (zforce < 0) ? 1'($urandom) : 1'(zforce);
      #1;
      n++; cyc_idx++;
      ev = e.v;
      if (e.ib) ev[11] = Zero;
      got = outs();
      if (n <= 40) snap[n] = got;
      if (PcEn && pc_first == 0) pc_first = n;
      mrd_n += int'(MemRead); mwr_n += int'(MemWrite);
      check("outputs", 32'(got), 32'(ev));
`ifdef CTRL_PERF_CNT_EN
      check("retire_cnt", RetireCnt, ret_model);
      if (ev[12]) ret_model++;
`endif
      @(negedge Clk);
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    Reset = 1'b1; Zero = 1'b1; MemReady = 1'b1;
    #1;
    check("reset_outputs", 32'(outs()), 32'h0);
`ifdef CTRL_PERF_CNT_EN
    ret_model = 0;
    check("reset_retire", RetireCnt, 32'h0);
`endif
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    bit h;
    int k, w, cut;
    logic [31:0] ins;
    repeat (2) @(negedge Clk);
    do_reset();

    build(32'h00228021, 0, 1'b0, h); run(100);
    check("addu_pcen_cycle", pc_first, 4);
    check("addu_cycle4", 32'(snap[4]), 32'(14'b01011000000010));

    build(32'h8c330002, 2, 1'b0, h); run(100);
    check("lw_pcen_cycle", pc_first, 7);
    check("lw_memread_cycles", mrd_n, 3);
    check("lw_cycle7", 32'(snap[7]), 32'(14'b01010110000110));

    zforce = 1; build(32'h1042ffe0, 0, 1'b0, h); run(100);
    check("beq_z1_cycle3", 32'(snap[3]), 32'(14'b01100000100010));
    zforce = 0; build(32'h1042ffe0, 0, 1'b0, h); run(100);
    check("beq_z0_cycle3", 32'(snap[3]), 32'(14'b01000000100010));
    check("beq_pcen_cycle", pc_first, 3);
    zforce = -1;

    build(32'hffffffff, 0, 1'b0, h); run(100);
    check("illegal_halt", 32'(snap[3]), 32'(14'b00000000000001));
    check("illegal_no_pcen", pc_first, 0);
    do_reset();

    build(32'h00000000, 0, 1'b0, h); run(100);
    check("zero_word_halt", 32'(snap[3]), 32'(14'b00000000000001));
    do_reset();

    build(32'hac310002, 0, 1'b1, h); run(100);
    check("sw_tmo_memwrite_cycles", mwr_n, 8);
    check("sw_tmo_cycle11", 32'(snap[11]), 32'(14'b00000110001010));
    check("sw_tmo_cycle12", 32'(snap[12]), 32'(14'b00000000000001));
    do_reset();

    build(32'h8c330002, 3, 1'b0, h); run(4);
    check("lw_mid_mem_read", mrd_n, 1);
    do_reset();

    for (int i = 0; i < 250; i++) begin
      k = int'($urandom_range(0, 7));
      ins = $urandom;
      case (k)
        K_ADDU: begin ins[31:26] = 6'h00; ins[5:0] = 6'h21; end
        K_SUBU: begin ins[31:26] = 6'h00; ins[5:0] = 6'h23; end
        K_ORI:  ins[31:26] = 6'h0d;
        K_LUI:  ins[31:26] = 6'h0f;
        K_LW:   ins[31:26] = 6'h23;
        K_SW:   ins[31:26] = 6'h2b;
        K_BEQ:  ins[31:26] = 6'h04;
        default: while (classify(ins) != K_ILL) ins = $urandom;
      endcase
      w = int'($urandom_range(0, WAIT_MAX - 1));
      build(ins, w, ($urandom_range(0, 9) == 0), h);
      if ($urandom_range(0, 11) == 0) begin
        cut = int'($urandom_range(1, 8));
        run(cut);
        do_reset();
      end else begin
        run(1000);
        if (h) do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
